// File: rtl/maze_pkg.sv
// Shared maze geometry for the generator, wall renderer and player movement.
// Cell id = row*5 + col; wall vector bit 1 means a wall is present.
package maze_pkg;

    localparam int MAZE_ROWS  = 4;
    localparam int MAZE_COLS  = 5;
    localparam int NUM_CELLS  = 20;
    localparam int WALL_BITS  = 31;
    localparam int VWALL_BASE = 0;
    localparam int HWALL_BASE = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_WALK,
        ST_DONE
    } gen_state_t;

    // Encoding matches the bit order of the {N,E,S,W} neighbour mask.
    typedef enum logic [1:0] {
        DIR_W = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_N = 2'd3
    } dir_t;

    function automatic logic [4:0] east_wall_idx(input logic [4:0] r,
                                                 input logic [4:0] c);
        return 5'(VWALL_BASE + (MAZE_COLS - 1) * r + c);
    endfunction

    function automatic logic [4:0] south_wall_idx(input logic [4:0] r,
                                                  input logic [4:0] c);
        return 5'(HWALL_BASE + MAZE_COLS * r + c);
    endfunction

    function automatic logic [4:0] cell_row(input logic [4:0] id);
        logic [4:0] r;
        if (id >= 5'd15)      r = 5'd3;
        else if (id >= 5'd10) r = 5'd2;
        else if (id >= 5'd5)  r = 5'd1;
        else                  r = 5'd0;
        return r;
    endfunction

    function automatic logic [4:0] cell_col(input logic [4:0] id);
        return 5'(id - MAZE_COLS * cell_row(id));
    endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400, shifting right) for the maze generator.
// Ports: clock; load/seed overwrite the state; enable advances it one step.
module maze_lfsr16 (
    input  logic        clock,
    input  logic        load,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // No reset: the state is always loaded before it is consumed.
    always_ff @(posedge clock) begin
        if (load)
            state <= seed;
        else if (enable)
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
    end

endmodule

// File: rtl/maze_generator.sv
// Randomized iterative DFS maze generator for the 5x4 grid.
// Ports: clock, reset (sync, active high), start, seed[15:0] in;
//        maze[30:0], maze_valid, busy, done out.
module maze_generator
    import maze_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          seed,
    output logic [WALL_BITS-1:0] maze,
    output logic                 maze_valid,
    output logic                 busy,
    output logic                 done
);

    gen_state_t state, state_next;

    logic [WALL_BITS-1:0] work;
    logic [NUM_CELLS-1:0] visited;
    logic [4:0]           stack [NUM_CELLS];
    logic [4:0]           sp;
    logic [4:0]           cur;

    logic [15:0] lfsr;
    logic [15:0] seed_value;
    logic        accept;

    logic [4:0] row, col;
    logic [4:0] nb_n, nb_e, nb_s, nb_w;
    logic [3:0] nmask, rot;
    logic [1:0] pos;
    dir_t       dir;
    logic [4:0] nb;
    logic [4:0] widx;
    logic       carve;

    assign accept     = (state == ST_IDLE) && start;
    assign seed_value = (seed == 16'h0) ? DEFAULT_SEED : seed;

    maze_lfsr16 u_lfsr (
        .clock  (clock),
        .load   (accept),
        .enable (state == ST_WALK),
        .seed   (seed_value),
        .state  (lfsr)
    );

    assign row  = cell_row(cur);
    assign col  = cell_col(cur);
    assign nb_n = cur - 5'd5;
    assign nb_e = cur + 5'd1;
    assign nb_s = cur + 5'd5;
    assign nb_w = cur - 5'd1;

    // Out-of-grid neighbours are masked before their visited bit matters.
    assign nmask[3] = (row != 5'd0) && !visited[nb_n];
    assign nmask[2] = (col != 5'(MAZE_COLS - 1)) && !visited[nb_e];
    assign nmask[1] = (row != 5'(MAZE_ROWS - 1)) && !visited[nb_s];
    assign nmask[0] = (col != 5'd0) && !visited[nb_w];
    assign carve    = |nmask;

    // Rotated position p holds original direction (p + lfsr[1:0]) mod 4.
    always_comb begin
        rot = 4'h0;
        for (int i = 0; i < 4; i++)
            rot[i] = nmask[2'(2'(i) + lfsr[1:0])];
        pos = 2'd0;
        if (rot[3])      pos = 2'd3;
        else if (rot[2]) pos = 2'd2;
        else if (rot[1]) pos = 2'd1;
        dir = dir_t'(2'(pos + lfsr[1:0]));
    end

    always_comb begin
        nb   = nb_e;
        widx = 5'd0;
        unique case (dir)
            DIR_N: begin
                nb   = nb_n;
                widx = south_wall_idx(row - 5'd1, col);
            end
            DIR_E: begin
                nb   = nb_e;
                widx = east_wall_idx(row, col);
            end
            DIR_S: begin
                nb   = nb_s;
                widx = south_wall_idx(row, col);
            end
            DIR_W: begin
                nb   = nb_w;
                widx = east_wall_idx(row, col - 5'd1);
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_INIT;
            ST_INIT: state_next = ST_WALK;
            ST_WALK: if (!carve && sp == 5'd1) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            maze       <= '0;
            maze_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) busy <= 1'b1;
                end
                ST_INIT: begin
                    work     <= '1;
                    visited  <= NUM_CELLS'(1);
                    stack[0] <= 5'd0;
                    sp       <= 5'd1;
                    cur      <= 5'd0;
                end
                ST_WALK: begin
                    if (carve) begin
                        work[widx]  <= 1'b0;
                        stack[sp]   <= nb;
                        sp          <= sp + 5'd1;
                        visited[nb] <= 1'b1;
                        cur         <= nb;
                    end else begin
                        sp <= sp - 5'd1;
                        if (sp != 5'd1) cur <= stack[sp - 5'd2];
                    end
                end
                ST_DONE: begin
                    maze       <= work;
                    maze_valid <= 1'b1;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_generator.sv
// Scoreboard bench for maze_generator: latency, structure, determinism, reset.
// Ports: none (drives clock/reset/start/seed, observes maze outputs).
module tb_maze_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] seed;
    logic [30:0] maze;
    logic        maze_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [30:0] last_maze = '0;

    typedef struct {
        logic [15:0] seed;
        int          due;
        bit          has_ref;
        logic [30:0] refm;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    maze_generator dut (
        .clock      (clk),
        .reset      (reset),
        .start      (start),
        .seed       (seed),
        .maze       (maze),
        .maze_valid (maze_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent connectivity count from cell 0 using the wall map.
    function automatic int reach_count(input logic [30:0] m);
        logic [19:0] rch;
        rch = 20'h1;
        repeat (20) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 5; c++) begin
                    int id;
                    id = r * 5 + c;
                    if (rch[id]) begin
                        if (c < 4 && !m[r*4+c])         rch[id+1] = 1'b1;
                        if (c > 0 && !m[r*4+c-1])       rch[id-1] = 1'b1;
                        if (r < 3 && !m[16+r*5+c])      rch[id+5] = 1'b1;
                        if (r > 0 && !m[16+(r-1)*5+c])  rch[id-5] = 1'b1;
                    end
                end
            end
        end
        return $countones(rch);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("done_cycle", cyc, e.due);
                check("valid_at_done", {31'b0, maze_valid}, 32'd1);
                check("wall_count", $countones(maze), 32'd12);
                check("reach", reach_count(maze), 32'd20);
                if (e.has_ref)
                    check("repeat_maze", {1'b0, maze}, {1'b0, e.refm});
            end
            last_maze = maze;
            done_cnt++;
        end
    end

    task automatic wait_done(input int prev);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(posedge clk);
            got = (done_cnt != prev);
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            sbq.delete();
        end
    endtask

    task automatic kick(input logic [15:0] s, input bit has_ref,
                        input logic [30:0] refm);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        sbq.push_back('{s, cyc + 42, has_ref, refm});
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", {31'b0, busy}, 32'd1);
    endtask

    task automatic run_one(input logic [15:0] s, input bit has_ref,
                           input logic [30:0] refm);
        int prev;
        prev = done_cnt;
        kick(s, has_ref, refm);
        wait_done(prev);
        @(negedge clk);
        check("busy_after", {31'b0, busy}, 32'd0);
        check("done_pulse", {31'b0, done}, 32'd0);
        check("valid_after", {31'b0, maze_valid}, 32'd1);
    endtask

    logic [30:0] m1234, m0, ma, mb;
    int prev;

    initial begin
        reset = 1'b1;
        start = 1'b1;
        seed  = 16'h1234;
        repeat (3) @(negedge clk);
        check("rst_maze", {1'b0, maze}, 32'd0);
        check("rst_valid", {31'b0, maze_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_valid", {31'b0, maze_valid}, 32'd0);

        run_one(16'h1234, 1'b0, '0);
        m1234 = last_maze;

        for (int i = 0; i < 200; i++)
            run_one(16'($urandom_range(1, 65535)), 1'b0, '0);

        run_one(16'h0000, 1'b0, '0);
        m0 = last_maze;
        run_one(16'hACE1, 1'b1, m0);
        run_one(16'h1234, 1'b1, m1234);

        run_one(16'h0BEE, 1'b0, '0);
        mb = last_maze;
        run_one(16'h7A11, 1'b0, '0);
        ma = last_maze;
        prev = done_cnt;
        kick(16'h0BEE, 1'b1, mb);
        seed = 16'h5555;
        repeat (9) begin
            @(negedge clk);
            check("t5_hold", {1'b0, maze}, {1'b0, ma});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_hold_pulse", {1'b0, maze}, {1'b0, ma});
        wait_done(prev);
        repeat (60) @(negedge clk);
        check("t5_one_done", done_cnt - prev, 32'd1);
        check("t5_idle", {31'b0, busy}, 32'd0);

        prev = done_cnt;
        kick(16'h2468, 1'b0, '0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_maze", {1'b0, maze}, 32'd0);
        check("t6_valid", {31'b0, maze_valid}, 32'd0);
        check("t6_done", {31'b0, done}, 32'd0);
        repeat (45) @(negedge clk);
        check("t6_no_done", done_cnt - prev, 32'd0);
        run_one(16'h2468, 1'b0, '0);

        check("sb_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
